regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (WEN/wsel/wdat) between NREQ writeback sources.
//  - Each source has a DEPTH-entry FIFO; a round-robin arbiter pops one entry per cycle.
//  - Write-port outputs are registered.
//  - A per-register pending-write counter gives the pipeline a hazard (busy) query.
//  - Sits between the writeback sources (ALU writeback, load return, mul/div) and the register file.

---
 rtl/regfile_wb_arbiter_if.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the writeback-source handshake, register-file write port and hazard query
// of regfile_wb_arbiter. Bypass signals exist only when WB_ARB_BYPASS_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int AW   = 5
);
  logic [NREQ-1:0]    reqValid;
  logic [NREQ-1:0]    reqReady;
  logic [NREQ*AW-1:0] reqSel;
  logic [NREQ*DW-1:0] reqDat;
  logic               rfWen;
  logic [AW-1:0]      rfWsel;
  logic [DW-1:0]      rfWdat;
  logic [AW-1:0]      pendSel;
  logic               pendBusy;
  logic               idle;
`ifdef WB_ARB_BYPASS_EN
  logic               bypHit;
  logic [DW-1:0]      bypDat;

  modport master (
    output reqValid, reqSel, reqDat, pendSel,
    input  reqReady, rfWen, rfWsel, rfWdat, pendBusy, idle, bypHit, bypDat
  );
  modport slave (
    input  reqValid, reqSel, reqDat, pendSel,
    output reqReady, rfWen, rfWsel, rfWdat, pendBusy, idle, bypHit, bypDat
  );
`else
  modport master (
    output reqValid, reqSel, reqDat, pendSel,
    input  reqReady, rfWen, rfWsel, rfWdat, pendBusy, idle
  );
  modport slave (
    input  reqValid, reqSel, reqDat, pendSel,
    output reqReady, rfWen, rfWsel, rfWdat, pendBusy, idle
  );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register file's single write port among NREQ writeback FIFOs,
// with per-register pending-write counters. Optional bypass lookup: define WB_ARB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input logic                i_clk,
  input logic                i_rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = $clog2(NREQ * DEPTH + 2);
  localparam int NREG = 2 ** AW;

  logic [AW-1:0]   r_fifoSel [NREQ][DEPTH];
  logic [DW-1:0]   r_fifoDat [NREQ][DEPTH];
  logic [PW-1:0]   r_rdPtr   [NREQ];
  logic [PW-1:0]   r_wrPtr   [NREQ];
  logic [CNTW-1:0] r_count   [NREQ];
  logic [IW-1:0]   r_rrPtr;
  logic            r_rfWen;
  logic [AW-1:0]   r_rfWsel;
  logic [DW-1:0]   r_rfWdat;
  logic [CW-1:0]   r_pend    [NREG];

  logic [NREQ-1:0] w_ready;
  logic [NREQ-1:0] w_push;
  logic [NREQ-1:0] w_pop;
  logic            w_grantValid;
  logic [IW-1:0]   w_grantIdx;
  logic [CW-1:0]   w_pendNext [NREG];
  logic            w_allEmpty;

  // Writes to register 0 complete the handshake but never enter a FIFO.
  always_comb begin
    w_ready = '0;
    w_push  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_ready[i] = (r_count[i] != CNTW'(DEPTH));
      w_push[i]  = bus.reqValid[i] && w_ready[i] && (bus.reqSel[i*AW +: AW] != '0);
    end
  end

  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = r_rrPtr;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_grantValid && r_count[IW'((int'(r_rrPtr) + k) % NREQ)] != '0) begin
        w_grantValid = 1'b1;
        w_grantIdx   = IW'((int'(r_rrPtr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_pop[i] = w_grantValid && (w_grantIdx == IW'(i));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREQ; i++) begin
        r_rdPtr[i] <= '0;
        r_wrPtr[i] <= '0;
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_push[i]) r_wrPtr[i] <= r_wrPtr[i] + PW'(1);
        if (w_pop[i])  r_rdPtr[i] <= r_rdPtr[i] + PW'(1);
        r_count[i] <= r_count[i] + CNTW'(w_push[i]) - CNTW'(w_pop[i]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (w_push[i]) begin
        r_fifoSel[i][r_wrPtr[i]] <= bus.reqSel[i*AW +: AW];
        r_fifoDat[i][r_wrPtr[i]] <= bus.reqDat[i*DW +: DW];
      end
    end
  end

  // Select and data hold their last value when no source is granted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rfWen  <= 1'b0;
      r_rfWsel <= '0;
      r_rfWdat <= '0;
      r_rrPtr  <= IW'(NREQ - 1);
    end else begin
      r_rfWen <= w_grantValid;
      if (w_grantValid) begin
        r_rfWsel <= r_fifoSel[w_grantIdx][r_rdPtr[w_grantIdx]];
        r_rfWdat <= r_fifoDat[w_grantIdx][r_rdPtr[w_grantIdx]];
        r_rrPtr  <= w_grantIdx;
      end
    end
  end

  // A write stays pending from enqueue until the end of its rf_wen cycle.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_pendNext[r] = r_pend[r];
      for (int i = 0; i < NREQ; i++) begin
        if (w_push[i] && bus.reqSel[i*AW +: AW] == AW'(r)) w_pendNext[r] = w_pendNext[r] + CW'(1);
      end
      if (r_rfWen && r_rfWsel == AW'(r)) w_pendNext[r] = w_pendNext[r] - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NREG; r++) r_pend[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) r_pend[r] <= w_pendNext[r];
    end
  end

  always_comb begin
    w_allEmpty = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (r_count[i] != '0) w_allEmpty = 1'b0;
    end
  end

  assign bus.reqReady = w_ready;
  assign bus.rfWen    = r_rfWen;
  assign bus.rfWsel   = r_rfWsel;
  assign bus.rfWdat   = r_rfWdat;
  assign bus.idle     = w_allEmpty && !r_rfWen;
  assign bus.pendBusy = (bus.pendSel != '0) && (r_pend[bus.pendSel] != '0);

`ifdef WB_ARB_BYPASS_EN
  logic          w_bypHit;
  logic [DW-1:0] w_bypDat;

  // With exactly one pending write, at most one live slot can match the query.
  always_comb begin
    w_bypHit = (bus.pendSel != '0) && (r_pend[bus.pendSel] == CW'(1));
    w_bypDat = '0;
    if (w_bypHit) begin
      if (r_rfWen && r_rfWsel == bus.pendSel) w_bypDat = r_rfWdat;
      for (int i = 0; i < NREQ; i++) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (CNTW'(k) < r_count[i] && r_fifoSel[i][r_rdPtr[i] + PW'(k)] == bus.pendSel) begin
            w_bypDat = r_fifoDat[i][r_rdPtr[i] + PW'(k)];
          end
        end
      end
    end
  end

  assign bus.bypHit = w_bypHit;
  assign bus.bypDat = w_bypDat;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based reference model.
// Define WB_ARB_BYPASS_EN for both RTL and bench to also cover the bypass outputs.
module tb_regfile_wb_arbiter;
  localparam int NREQ  = 2;
  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int AW    = 5;

  typedef struct packed {
    logic [AW-1:0] sel;
    logic [DW-1:0] dat;
  } wrEntry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   passCount  = 0;

  wrEntry_t      mQ [NREQ][$];
  int            mRr;
  logic          mWen;
  logic [AW-1:0] mWsel;
  logic [DW-1:0] mWdat;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  regfile_wb_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Pending writes for a register are all model entries still queued or on the write port.
  function automatic int pendingCount(input logic [AW-1:0] sel);
    int n = 0;
    for (int i = 0; i < NREQ; i++)
      foreach (mQ[i][j]) if (mQ[i][j].sel == sel) n++;
    if (mWen && mWsel == sel) n++;
    return n;
  endfunction

  function automatic logic [DW-1:0] pendingData(input logic [AW-1:0] sel);
    logic [DW-1:0] d = '0;
    for (int i = 0; i < NREQ; i++)
      foreach (mQ[i][j]) if (mQ[i][j].sel == sel) d = mQ[i][j].dat;
    if (mWen && mWsel == sel) d = mWdat;
    return d;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NREQ; i++) mQ[i].delete();
    mRr   = NREQ - 1;
    mWen  = 1'b0;
    mWsel = '0;
    mWdat = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic modelEdge();
    logic [NREQ-1:0] acc;
    int g = -1;
    wrEntry_t e;
    for (int i = 0; i < NREQ; i++) acc[i] = bus.reqValid[i] && (mQ[i].size() < DEPTH);
    for (int k = 1; k <= NREQ; k++) begin
      if (g < 0 && mQ[(mRr + k) % NREQ].size() > 0) g = (mRr + k) % NREQ;
    end
    if (g >= 0) begin
      e     = mQ[g].pop_front();
      mWen  = 1'b1;
      mWsel = e.sel;
      mWdat = e.dat;
      mRr   = g;
    end else begin
      mWen = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && bus.reqSel[i*AW +: AW] != '0) begin
        e.sel = bus.reqSel[i*AW +: AW];
        e.dat = bus.reqDat[i*DW +: DW];
        mQ[i].push_back(e);
      end
    end
  endtask

  task automatic compareAll(input string tg);
    logic [NREQ-1:0] expReady;
    logic            expIdle = ~mWen;
    int              cnt = pendingCount(bus.pendSel);
    for (int i = 0; i < NREQ; i++) begin
      expReady[i] = (mQ[i].size() < DEPTH);
      if (mQ[i].size() != 0) expIdle = 1'b0;
    end
    checkOutput({tg, "_wen"}, 64'(bus.rfWen), 64'(mWen));
    checkOutput({tg, "_wsel"}, 64'(bus.rfWsel), 64'(mWsel));
    checkOutput({tg, "_wdat"}, 64'(bus.rfWdat), 64'(mWdat));
    checkOutput({tg, "_ready"}, 64'(bus.reqReady), 64'(expReady));
    checkOutput({tg, "_idle"}, 64'(bus.idle), 64'(expIdle));
    checkOutput({tg, "_busy"}, 64'(bus.pendBusy), 64'((bus.pendSel != '0) && (cnt != 0)));
`ifdef WB_ARB_BYPASS_EN
    checkOutput({tg, "_bhit"}, 64'(bus.bypHit), 64'((bus.pendSel != '0) && (cnt == 1)));
    checkOutput({tg, "_bdat"}, 64'(bus.bypDat),
                64'(((bus.pendSel != '0) && (cnt == 1)) ? pendingData(bus.pendSel) : '0));
`endif
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] s,
                               input logic [NREQ*DW-1:0] d, input logic [AW-1:0] ps,
                               input string tg);
    bus.reqValid = v;
    bus.reqSel   = s;
    bus.reqDat   = d;
    bus.pendSel  = ps;
    #1;
    compareAll(tg);
    modelEdge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset(input int n);
    rst          = 1'b1;
    bus.reqValid = '0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    bus.reqValid = '0;
    bus.reqSel   = '0;
    bus.reqDat   = '0;
    bus.pendSel  = '0;
    modelReset();
    doReset(2);

    bus.pendSel = 5'd5;
    #1;
    checkOutput("rst_wen", 64'(bus.rfWen), 64'd0);
    checkOutput("rst_wsel", 64'(bus.rfWsel), 64'd0);
    checkOutput("rst_wdat", 64'(bus.rfWdat), 64'd0);
    checkOutput("rst_ready", 64'(bus.reqReady), 64'h3);
    checkOutput("rst_idle", 64'(bus.idle), 64'd1);
    checkOutput("rst_busy", 64'(bus.pendBusy), 64'd0);

    applyStimulus(2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF}, 5'd5, "t2_push");
    applyStimulus(2'b00, '0, '0, 5'd5, "t2_wait");
    checkOutput("t2_wen", 64'(bus.rfWen), 64'd1);
    checkOutput("t2_wsel", 64'(bus.rfWsel), 64'd5);
    checkOutput("t2_wdat", 64'(bus.rfWdat), 64'hDEADBEEF);
    checkOutput("t2_busy_on", 64'(bus.pendBusy), 64'd1);
    applyStimulus(2'b00, '0, '0, 5'd5, "t2_out");
    checkOutput("t2_wen_off", 64'(bus.rfWen), 64'd0);
    checkOutput("t2_busy_off", 64'(bus.pendBusy), 64'd0);

    for (int c = 0; c < 12; c++) begin
      applyStimulus(2'b11, {AW'(10 + c % 3), AW'(1 + c % 3)}, {$urandom, $urandom},
                    AW'($urandom_range(0, 12)), "t3_both");
    end
    repeat (6) applyStimulus(2'b00, '0, '0, AW'($urandom_range(0, 12)), "t3_drain");

    applyStimulus(2'b01, {5'd0, 5'd0}, {32'd0, 32'h1234}, 5'd0, "t5_zero");
    repeat (2) applyStimulus(2'b00, '0, '0, 5'd0, "t5_wait");
    checkOutput("t5_idle", 64'(bus.idle), 64'd1);
    checkOutput("t5_wen", 64'(bus.rfWen), 64'd0);

    applyStimulus(2'b11, {5'd7, 5'd7}, {32'hB7B7B7B7, 32'hA7A7A7A7}, 5'd7, "t6_push");
`ifdef WB_ARB_BYPASS_EN
    #1;
    checkOutput("t6_hit_two", 64'(bus.bypHit), 64'd0);
`endif
    applyStimulus(2'b00, '0, '0, 5'd7, "t6_two");
    applyStimulus(2'b00, '0, '0, 5'd7, "t6_two_b");
`ifdef WB_ARB_BYPASS_EN
    checkOutput("t6_hit_one", 64'(bus.bypHit), 64'd1);
`endif
    applyStimulus(2'b00, '0, '0, 5'd7, "t6_one");
    applyStimulus(2'b11, {5'd7, 5'd7}, {32'hD7D7D7D7, 32'hC7C7C7C7}, 5'd7, "t6_push2");
    applyStimulus(2'b00, '0, '0, 5'd7, "t6_pre");
    doReset(1);
    bus.pendSel = 5'd7;
    #1;
    checkOutput("t6_wen", 64'(bus.rfWen), 64'd0);
    checkOutput("t6_busy", 64'(bus.pendBusy), 64'd0);
    checkOutput("t6_idle", 64'(bus.idle), 64'd1);
    repeat (3) applyStimulus(2'b00, '0, '0, 5'd7, "t6_after");

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) doReset(1);
      applyStimulus(NREQ'($urandom_range(0, 3)),
                    {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))},
                    {$urandom, $urandom}, AW'($urandom_range(0, 7)), "rnd");
    end
    repeat (6) applyStimulus(2'b00, '0, '0, AW'($urandom_range(0, 7)), "rnd_drain");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
